// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths, FSM states and request record for the GPR arbiter
package gpr_pkg;
   localparam int AW = 4;
   localparam int DW = 10;
   localparam int NREGS = 10;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
   typedef struct packed {
      logic we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } gpr_req_t;
endpackage

// File: rtl/gpr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick starting at ptr
module rr_arbiter import gpr_pkg::*; #(
   parameter int NREQ = 3,
   parameter int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            found
);
   logic [IW-1:0] j;
   // scan from ptr upward with wrap; the first pending requester wins
   always_comb begin
      gnt = '0;
      idx = '0;
      found = 1'b0;
      j = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = IW'((int'(ptr) + k) % NREQ);
         if (en && !found && req[j]) begin
            found = 1'b1;
            idx = j;
            gnt[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/gpr_arbiter.sv
// gpr_arbiter: round-robin access sequencer for the shared single-port register file
module gpr_arbiter import gpr_pkg::*; #(
   parameter int NREQ = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic [AW-1:0]     gpr_addr,
   output logic [DW-1:0]     gpr_indata,
   output logic              gpr_read,
   output logic              gpr_write,
   input  logic [DW-1:0]     gpr_outdata
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   arb_state_t state;
   gpr_req_t hold;
   logic [IW-1:0] ptr, gidx, widx;
   logic found, legal, acc;
   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req(req_valid),
      .ptr(ptr),
      .en(state == IDLE && !rst),
      .gnt(req_ready),
      .idx(widx),
      .found(found)
   );
   assign legal = hold.addr < AW'(NREGS);
   assign acc = state == ACCESS;
   assign gpr_addr = acc ? hold.addr : '0;
   assign gpr_write = acc && legal && hold.we;
   assign gpr_read = acc && legal && !hold.we;
   assign gpr_indata = gpr_write ? hold.wdata : '0;
   // accept -> access -> respond; rotate priority past each winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         gidx <= '0;
         hold <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (found) begin
               hold <= '{we: req_we[widx], addr: req_addr[widx*AW +: AW], wdata: req_wdata[widx*DW +: DW]};
               gidx <= widx;
               ptr <= (widx == IW'(NREQ-1)) ? '0 : widx + 1'b1;
               state <= ACCESS;
            end
            ACCESS: begin
               rsp_rdata <= (legal && !hold.we) ? gpr_outdata : '0;
               rsp_err <= !legal;
               rsp_valid <= NREQ'(1) << gidx;
               state <= RESP;
            end
            RESP: begin
               rsp_valid <= '0;
               rsp_rdata <= '0;
               rsp_err <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpr_arbiter.sv
// tb_gpr_arbiter: directed and random checks of gpr_arbiter against a transaction-level model
module tb_gpr_arbiter;
   import gpr_pkg::*;
   localparam int N = 3;
   logic clk = 1'b0, rst = 1'b0;
   logic [N-1:0] req_valid = '0, req_we = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0] req_ready, rsp_valid;
   logic [DW-1:0] rsp_rdata, gpr_indata, gpr_outdata;
   logic rsp_err, gpr_read, gpr_write;
   logic [AW-1:0] gpr_addr;
   logic [DW-1:0] rf [16];
   logic [DW-1:0] ref_mem [16];
   int checks = 0, errors = 0;
   int mphase = 0, mptr = 0, mg = 0;
   logic mwe = 1'b0;
   logic [AW-1:0] maddr = '0;
   logic [DW-1:0] mwdata = '0;
   logic [N-1:0] acc;
   int gt [$];

   gpr_arbiter #(.NREQ(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .gpr_addr(gpr_addr), .gpr_indata(gpr_indata), .gpr_read(gpr_read),
      .gpr_write(gpr_write), .gpr_outdata(gpr_outdata)
   );

   always #5 clk = ~clk;

   // register file: 16 slots so stray writes to illegal addresses are visible
   always @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < 16; i++) rf[i] <= '0;
      else if (gpr_write) rf[gpr_addr] <= gpr_indata;
   assign gpr_outdata = gpr_read ? rf[gpr_addr] : 'z;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = v;
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   // one clock cycle: compare outputs with the transaction model, then advance it
   task automatic cyc();
      int w;
      logic lg;
      logic [N-1:0] er;
      #1;
      w = -1;
      if (mphase == 0)
         for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(mptr+k)%N]) w = (mptr + k) % N;
      er = (w >= 0) ? N'(1) << w : '0;
      acc = er;
      lg = int'(maddr) < NREGS;
      chk("req_ready", req_ready, er);
      chk("gpr_write", gpr_write, mphase == 1 && lg && mwe);
      chk("gpr_read", gpr_read, mphase == 1 && lg && !mwe);
      chk("gpr_addr", gpr_addr, mphase == 1 ? maddr : 4'd0);
      if (mphase == 1 && lg && mwe) chk("gpr_indata", gpr_indata, mwdata);
      chk("rsp_valid", rsp_valid, mphase == 2 ? N'(1) << mg : 3'd0);
      chk("rsp_err", rsp_err, mphase == 2 && !lg);
      if (mphase == 2) chk("rsp_rdata", rsp_rdata, (lg && !mwe) ? ref_mem[maddr] : 10'd0);
      if (mphase == 0) begin
         if (w >= 0) begin
            mg = w;
            mwe = req_we[w];
            maddr = req_addr[w*AW +: AW];
            mwdata = req_wdata[w*DW +: DW];
            mptr = (w + 1) % N;
            mphase = 1;
         end
      end else if (mphase == 1) begin
         if (lg && mwe) ref_mem[maddr] = mwdata;
         mphase = 2;
      end else mphase = 0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_outs", {req_ready, rsp_valid, rsp_rdata, rsp_err, gpr_read, gpr_write, gpr_addr, gpr_indata}, '0);
      mphase = 0;
      mptr = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2;
      do_reset();
      set_req(0, 1, 1, 4'd3, 10'h2A5);
      #1 chk("t1_ready", req_ready, 3'b001);
      cyc();
      set_req(0, 0, 0, 0, 0);
      #1 chk("t1_write", {gpr_write, gpr_addr}, {1'b1, 4'd3});
      cyc();
      #1 chk("t1_rsp", {rsp_valid, rsp_err}, {3'b001, 1'b0});
      cyc();
      set_req(0, 1, 0, 4'd3, 0);
      cyc();
      set_req(0, 0, 0, 0, 0);
      cyc();
      #1 chk("t1_rdata", rsp_rdata, 10'h2A5);
      cyc();
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(i), 0);
      for (int c = 0; c < 18; c++) begin
         #1 if (req_ready != 0) gt.push_back(int'(req_ready));
         cyc();
      end
      chk("t2_count", gt.size(), 6);
      for (int k = 0; k < 6; k++) chk($sformatf("t2_order%0d", k), gt[k], 1 << (k % 3));
      for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0);
      set_req(2, 1, 1, 4'd7, 10'h155);
      cyc();
      set_req(2, 0, 0, 0, 0);
      set_req(0, 1, 0, 4'd7, 0);
      cyc();
      cyc();
      #1 chk("t3_ready0", req_ready, 3'b001);
      cyc();
      set_req(0, 0, 0, 0, 0);
      cyc();
      #1 chk("t3_rdata", rsp_rdata, 10'h155);
      cyc();
      set_req(1, 1, 0, 4'd12, 0);
      cyc();
      set_req(1, 0, 0, 0, 0);
      #1 chk("t4_noacc", {gpr_read, gpr_write}, 2'b00);
      cyc();
      #1 chk("t4_err", {rsp_valid, rsp_err, rsp_rdata}, {3'b010, 1'b1, 10'd0});
      cyc();
      set_req(1, 1, 1, 4'd10, 10'h3FF);
      cyc();
      set_req(1, 0, 0, 0, 0);
      cyc();
      cyc();
      set_req(1, 1, 0, 4'd5, 0);
      cyc();
      set_req(1, 0, 0, 0, 0);
      #1 chk("t5_in_access", gpr_read, 1'b1);
      do_reset();
      set_req(1, 1, 0, 4'd5, 0);
      set_req(2, 1, 0, 4'd6, 0);
      #1 chk("t5_regrant", req_ready, 3'b010);
      cyc();
      set_req(1, 0, 0, 0, 0);
      cyc();
      cyc();
      gt.delete();
      for (int c = 0; c < 9; c++) begin
         #1 if (req_ready[2]) gt.push_back(c);
         cyc();
      end
      set_req(2, 0, 0, 0, 0);
      chk("t6_count", gt.size(), 3);
      for (int k = 0; k < 3; k++) chk($sformatf("t6_slot%0d", k), gt[k], 3 * k);
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i]) begin
               if ($urandom_range(0, 1) == 1)
                  set_req(i, 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 1023)));
            end else if ($urandom_range(0, 15) == 0) set_req(i, 0, 0, 0, 0);
         cyc();
         for (int i = 0; i < N; i++) if (acc[i]) set_req(i, 0, 0, 0, 0);
      end
      for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0);
      cyc();
      cyc();
      cyc();
      for (int i = 0; i < 16; i++) chk($sformatf("rf%0d", i), rf[i], ref_mem[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gpr_arbiter.md
Name: gpr_arbiter

Overview:
Shares the single-port 10x10-bit general-purpose register file between NREQ independent requesters (control unit, I/O loader, debug port).
- Round-robin arbitration with a valid/ready request handshake.
- Sequences each access as a fixed 3-cycle transaction: accept, access, respond.
- Range-checks addresses and returns read data and an error flag per transaction.
- Sits between the requesters and the register file's addr/indata/read/write/outdata port.

Parameters:
NREQ, 3, number of requesters (2..4)
AW, 4, register address width
DW, 10, data width
NREGS, 10, number of implemented registers; addresses >= NREGS are illegal

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  NREQ  request pending, one bit per requester
req_we  in  NREQ  1 = write, 0 = read, per requester
req_addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW]
req_ready  out  NREQ  one-hot accept pulse
rsp_valid  out  NREQ  one-hot response pulse, to the granted requester
rsp_rdata  out  DW  read data (shared bus)
rsp_err  out  1  address out of range (shared, qualified by rsp_valid)
gpr_addr  out  AW  register file address
gpr_indata  out  DW  register file write data
gpr_read  out  1  register file read enable
gpr_write  out  1  register file write enable
gpr_outdata  in  DW  register file read data; high-Z when gpr_read = 0

Behaviour:
Reset values:
- All outputs 0.
- FSM = IDLE.
- Round-robin pointer = 0.
- Hold registers (grant index, we, addr, wdata) cleared.

FSM:
- IDLE:
  - Search req_valid from the pointer upward, wrapping modulo NREQ; the first set bit wins (index g).
  - If found: req_ready[g] = 1 combinationally this cycle; latch we, addr and wdata of g and g itself; pointer <= (g+1) mod NREQ; next state ACCESS.
  - If none: stay in IDLE; pointer unchanged.
- ACCESS (exactly 1 cycle):
  - gpr_addr = held addr.
  - Legal write (addr < NREGS): gpr_write = 1, gpr_indata = held wdata. The register file updates at the end of this cycle.
  - Legal read: gpr_read = 1; gpr_outdata is sampled into rsp_rdata at the clock edge.
  - Illegal addr: gpr_read = gpr_write = 0; rsp_rdata <= 0; err flag <= 1.
  - Next state RESP.
- RESP (exactly 1 cycle):
  - rsp_valid[g] = 1; rsp_rdata and rsp_err are stable.
  - rsp_rdata = 0 for writes.
  - Next state IDLE.

Handshake and timing:
- A request is consumed only in the cycle where req_valid[i] & req_ready[i].
- A requester must hold valid, we, addr and wdata stable until it sees ready.
- There is no response backpressure; requesters must accept rsp_valid whenever it arrives.

Outside ACCESS:
- gpr_read = gpr_write = 0 and gpr_addr = 0.
- gpr_outdata is never sampled, so the high-Z value is never captured.

Latency and throughput:
- Accept in cycle N, register file access in N+1, response in N+2.
- Maximum throughput is 1 transaction per 3 cycles.

Boundary conditions:
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by rotating priority. Under contention no requester waits more than NREQ-1 transactions.
- Read after write from different requesters: the read sees the new value, because the write commits before the later ACCESS cycle.
- Pointer wrap: after a grant to NREQ-1 the pointer becomes 0.
- rst mid-transaction: the transaction is aborted with no rsp_valid. A write still in ACCESS may or may not have committed; the register file is reset anyway.
- req_valid dropped before ready: no effect, nothing is latched.

Decomposition:
- Package gpr_pkg:
  - AW, DW, NREGS constants.
  - typedef enum {IDLE, ACCESS, RESP} arb_state_t.
  - typedef struct {we, addr, wdata} gpr_req_t.
- Sub-module rr_arbiter (NREQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, grant index, found flag.
  - Purely combinational; the pointer register stays in gpr_arbiter.

Test Plan:
- Reset, then requester 0 writes 0x2A5 to addr 3 -> ready[0] at cycle 0, gpr_write=1/gpr_addr=3 at cycle 1, rsp_valid[0] at cycle 2 with rsp_err=0; a following read of addr 3 returns 0x2A5.
- All 3 requesters hold valid continuously, each reading its own index -> grant order 0,1,2,0,1,2; rsp_valid spaced exactly 3 cycles apart.
- Requester 2 writes 0x155 to addr 7 while requester 0 is waiting to read addr 7 -> requester 0's rsp_rdata = 0x155.
- Requester 1 reads addr 12 -> gpr_read and gpr_write stay 0; rsp_valid[1] with rsp_err=1 and rsp_rdata=0. Writing 0x3FF to addr 10 leaves all registers unchanged.
- rst asserted during ACCESS of a read -> no rsp_valid; all outputs 0 immediately; the pointer restarts at 0, so the next grant goes to the lowest valid requester.
- Only requester 2 valid, after a previous grant to requester 2 -> pointer wraps to 0, requester 2 is granted again with no idle gap beyond the FSM's 3-cycle cadence.
